// File: rtl/clock_divider.sv
// clock_divider
//   Synchronous integer divider that turns the system clock into a slow,
//   registered square wave plus a one-cycle strobe at each rising edge of
//   that wave. All state lives in the CLK domain.
//
// Parameters
//   DIV    : CLK cycles per slowCLK period (integer >= 2)
//   CNT_W  : phase counter width, must hold DIV-1
//
// Ports
//   CLK     in  : system clock, all state changes on its rising edge
//   RESET   in  : synchronous, active-high; clears counter and both outputs
//   slowCLK out : low for floor(DIV/2) cycles, then high for ceil(DIV/2)
//   tick    out : one-cycle pulse during the first high cycle of slowCLK
module clock_divider #(
  parameter int unsigned DIV   = 1000,
  parameter int unsigned CNT_W = $clog2(DIV)
) (
  input  logic CLK,
  input  logic RESET,
  output logic slowCLK,
  output logic tick
);

  localparam logic [CNT_W-1:0] HALF = CNT_W'(DIV / 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // Next phase: wrap explicitly at DIV-1 so the counter never reaches DIV,
  // which matters whenever DIV is not a power of two.
  always_comb begin
    cnt_next = cnt + ONE;
    if (cnt == LAST) begin
      cnt_next = '0;
    end
  end

  // Counter and outputs register together: the outputs are decoded from
  // cnt_next so they always match the current cnt with no combinational
  // path from the counter to the ports.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt     <= '0;
      slowCLK <= 1'b0;
      tick    <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      slowCLK <= (cnt_next >= HALF);
      tick    <= (cnt_next == HALF);
    end
  end

endmodule

// File: tb/tb_clock_divider.sv
// tb_clock_divider
//   Bench for clock_divider at DIV=1000 (long-run and reset scenarios),
//   DIV=5 (odd ratio) and DIV=2 (minimum ratio). Each instance has its own
//   reset so the scenarios can be driven independently from one clock.
module tb_clock_divider;

  typedef struct packed {
    logic rst;
    logic slow;
    logic tick;
  } vec_t;

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  logic slow_a, tick_a, slow_b, tick_b, slow_c, tick_c;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  clock_divider #(.DIV(1000)) u_div1000 (
    .CLK(clk), .RESET(rst_a), .slowCLK(slow_a), .tick(tick_a)
  );

  clock_divider #(.DIV(5)) u_div5 (
    .CLK(clk), .RESET(rst_b), .slowCLK(slow_b), .tick(tick_b)
  );

  clock_divider #(.DIV(2)) u_div2 (
    .CLK(clk), .RESET(rst_c), .slowCLK(slow_c), .tick(tick_c)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic s, input logic t);
    vec_t v;
    v.rst  = r;
    v.slow = s;
    v.tick = t;
    return v;
  endfunction

  // DIV=1000: after edge k with no reset, slowCLK=(k mod 1000)>=500 and
  // tick=(k mod 1000)==500. Also tallies duty and ticks per period.
  task automatic run_div1000(input int edges, input string tag);
    int highs;
    int lows;
    int ticks;
    highs = 0;
    lows  = 0;
    ticks = 0;
    for (int k = 1; k <= edges; k++) begin
      step();
      check({tag, " slowCLK"}, int'(slow_a), int'((k % 1000) >= 500));
      check({tag, " tick"},    int'(tick_a), int'((k % 1000) == 500));
      if (slow_a) highs++; else lows++;
      if (tick_a) ticks++;
      if ((k % 1000) == 0) begin
        check({tag, " high cycles/period"}, highs, 500);
        check({tag, " low cycles/period"},  lows,  500);
        check({tag, " ticks/period"},       ticks, 1);
        highs = 0;
        lows  = 0;
        ticks = 0;
      end
    end
  endtask

  vec_t tab5[$];
  vec_t tab2[$];

  initial begin
    int n;

    rst_a = 1'b1;
    rst_b = 1'b1;
    rst_c = 1'b1;

    // DIV=5 vectors: rst applied before the edge, outputs expected after it.
    tab5.push_back(mk(1, 0, 0));
    tab5.push_back(mk(1, 0, 0));
    tab5.push_back(mk(0, 0, 0)); // cnt 1
    tab5.push_back(mk(0, 1, 1)); // cnt 2
    tab5.push_back(mk(0, 1, 0)); // cnt 3
    tab5.push_back(mk(0, 1, 0)); // cnt 4
    tab5.push_back(mk(0, 0, 0)); // cnt 0
    tab5.push_back(mk(0, 0, 0)); // cnt 1
    tab5.push_back(mk(0, 1, 1)); // cnt 2
    tab5.push_back(mk(0, 1, 0)); // cnt 3
    tab5.push_back(mk(1, 0, 0)); // reset mid high phase
    tab5.push_back(mk(0, 0, 0)); // cnt 1
    tab5.push_back(mk(0, 1, 1)); // cnt 2
    tab5.push_back(mk(0, 1, 0)); // cnt 3
    tab5.push_back(mk(0, 1, 0)); // cnt 4
    tab5.push_back(mk(1, 0, 0)); // reset coinciding with wrap
    tab5.push_back(mk(0, 0, 0)); // cnt 1
    tab5.push_back(mk(0, 1, 1)); // cnt 2

    // DIV=2 vectors: toggles every cycle, tick identical to slowCLK.
    tab2.push_back(mk(1, 0, 0));
    tab2.push_back(mk(0, 1, 1)); // cnt 1
    tab2.push_back(mk(0, 0, 0)); // cnt 0
    tab2.push_back(mk(0, 1, 1));
    tab2.push_back(mk(0, 0, 0));
    tab2.push_back(mk(0, 1, 1));
    tab2.push_back(mk(1, 0, 0)); // reset while cnt=1 (wrap point)
    tab2.push_back(mk(0, 1, 1));
    tab2.push_back(mk(0, 0, 0));
    tab2.push_back(mk(1, 0, 0)); // reset from cnt 0
    tab2.push_back(mk(1, 0, 0));
    tab2.push_back(mk(0, 1, 1));

    // DIV=1000: three reset cycles, then five full periods.
    repeat (3) begin
      step();
      check("reset slowCLK", int'(slow_a), 0);
      check("reset tick",    int'(tick_a), 0);
    end
    rst_a = 1'b0;
    run_div1000(5000, "run");

    // Mid-period reset at cnt=750 while slowCLK is high.
    repeat (750) step();
    check("pre-reset slowCLK at cnt 750", int'(slow_a), 1);
    check("pre-reset tick at cnt 750",    int'(tick_a), 0);
    rst_a = 1'b1;
    step();
    check("mid reset slowCLK", int'(slow_a), 0);
    check("mid reset tick",    int'(tick_a), 0);
    rst_a = 1'b0;
    n = 0;
    while (!slow_a && n < 2000) begin
      step();
      n++;
    end
    check("edges to first rise after mid reset", n, 500);
    check("tick at rise after mid reset", int'(tick_a), 1);
    step();
    check("tick one cycle only", int'(tick_a), 0);
    check("slowCLK stays high",  int'(slow_a), 1);

    // Reset held for 20 cycles, then the normal sequence from the start.
    rst_a = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("held reset slowCLK", int'(slow_a), 0);
      check("held reset tick",    int'(tick_a), 0);
    end
    rst_a = 1'b0;
    run_div1000(2000, "after held reset");
    rst_a = 1'b1;

    // DIV=5 table.
    foreach (tab5[i]) begin
      rst_b = tab5[i].rst;
      step();
      check($sformatf("div5 slowCLK row %0d", i), int'(slow_b), int'(tab5[i].slow));
      check($sformatf("div5 tick row %0d", i),    int'(tick_b), int'(tab5[i].tick));
    end

    // DIV=2 table.
    foreach (tab2[i]) begin
      rst_c = tab2[i].rst;
      step();
      check($sformatf("div2 slowCLK row %0d", i), int'(slow_c), int'(tab2[i].slow));
      check($sformatf("div2 tick row %0d", i),    int'(tick_c), int'(tab2[i].tick));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
